// File: rtl/pgm_rom_loader.sv
// Program-ROM loader: packs HPS download bytes into 16-bit ROM writes, pads the unwritten tail,
// and holds the CPU in reset across the load plus a settle period.
module pgm_rom_loader #(
  parameter int unsigned ADDR_W      = 14,
  parameter bit          FILL_EN     = 1'b1,
  parameter logic [15:0] FILL_WORD   = 16'hFFFF,
  parameter int unsigned HOLD_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [ADDR_W:0]   ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic [ADDR_W:0]   load_words
);

  localparam int unsigned     CntW     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CntW-1:0] HoldLoad = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [ADDR_W:0] Depth    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LastAddr = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] One      = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {StLoad, StFlush, StPad, StHold, StRun} state_e;

  state_e            state_q;
  logic              dl_q;
  logic              pend_valid_q;
  logic [7:0]        pend_byte_q;
  logic [ADDR_W-1:0] pend_word_q;
  logic [ADDR_W:0]   hwm_q;
  logic [ADDR_W:0]   pad_addr_q;
  logic [CntW-1:0]   hold_cnt_q;

  logic [ADDR_W-1:0] byte_word;
  logic              dl_rise;
  logic              dl_fall;
  logic [ADDR_W:0]   wr_end;
  logic [ADDR_W:0]   wr_hwm;
  logic [ADDR_W:0]   fl_end;
  logic [ADDR_W:0]   fl_hwm;
  logic              pad_after_load;
  logic              pad_after_flush;

  assign byte_word = ioctl_addr[ADDR_W:1];
  assign dl_rise   = ioctl_download & ~dl_q;
  assign dl_fall   = ~ioctl_download & dl_q;

  // High-water mark is one past the highest word written; ADDR_W+1 bits so a full ROM fits.
  assign wr_end = {1'b0, byte_word} + One;
  assign wr_hwm = (wr_end > hwm_q) ? wr_end : hwm_q;
  assign fl_end = {1'b0, pend_word_q} + One;
  assign fl_hwm = (fl_end > hwm_q) ? fl_end : hwm_q;

  assign pad_after_load  = FILL_EN && (hwm_q < Depth);
  assign pad_after_flush = FILL_EN && (fl_hwm < Depth);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StHold;
      hold_cnt_q   <= HoldLoad;
      dl_q         <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_byte_q  <= 8'h00;
      pend_word_q  <= '0;
      hwm_q        <= '0;
      pad_addr_q   <= '0;
      cpu_rst      <= 1'b1;
      busy         <= 1'b1;
      mem_we       <= 1'b0;
      mem_waddr    <= '0;
      mem_wdata    <= 16'h0000;
      load_words   <= '0;
    end else begin
      dl_q   <= ioctl_download;
      mem_we <= 1'b0;
      if (dl_rise) begin
        // A fresh download pre-empts whatever was in progress, including pad and hold.
        state_q      <= StLoad;
        cpu_rst      <= 1'b1;
        busy         <= 1'b1;
        pend_valid_q <= 1'b0;
        hwm_q        <= '0;
        load_words   <= '0;
      end else begin
        unique case (state_q)
          StLoad: begin
            if (dl_fall) begin
              if (pend_valid_q) begin
                state_q <= StFlush;
              end else if (pad_after_load) begin
                state_q    <= StPad;
                pad_addr_q <= hwm_q;
              end else begin
                state_q    <= StHold;
                hold_cnt_q <= HoldLoad;
              end
            end else if (ioctl_wr) begin
              if (!ioctl_addr[0]) begin
                pend_byte_q  <= ioctl_dout;
                pend_word_q  <= byte_word;
                pend_valid_q <= 1'b1;
              end else begin
                pend_valid_q <= 1'b0;
                if (pend_valid_q && (pend_word_q == byte_word)) begin
                  mem_we     <= 1'b1;
                  mem_waddr  <= byte_word;
                  mem_wdata  <= {ioctl_dout, pend_byte_q};
                  load_words <= load_words + One;
                  hwm_q      <= wr_hwm;
                end
              end
            end
          end
          StFlush: begin
            // Odd-length file: the orphan low byte gets an erased high byte.
            mem_we       <= 1'b1;
            mem_waddr    <= pend_word_q;
            mem_wdata    <= {8'hFF, pend_byte_q};
            pend_valid_q <= 1'b0;
            load_words   <= load_words + One;
            hwm_q        <= fl_hwm;
            if (pad_after_flush) begin
              state_q    <= StPad;
              pad_addr_q <= fl_hwm;
            end else begin
              state_q    <= StHold;
              hold_cnt_q <= HoldLoad;
            end
          end
          StPad: begin
            mem_we     <= 1'b1;
            mem_waddr  <= pad_addr_q[ADDR_W-1:0];
            mem_wdata  <= FILL_WORD;
            pad_addr_q <= pad_addr_q + One;
            if (pad_addr_q == LastAddr) begin
              state_q    <= StHold;
              hold_cnt_q <= HoldLoad;
            end
          end
          StHold: begin
            if (hold_cnt_q == '0) begin
              state_q <= StRun;
              cpu_rst <= 1'b0;
              busy    <= 1'b0;
            end else begin
              hold_cnt_q <= hold_cnt_q - CntOne;
            end
          end
          StRun: begin
            cpu_rst <= 1'b0;
            busy    <= 1'b0;
          end
          default: begin
            state_q    <= StHold;
            hold_cnt_q <= HoldLoad;
            cpu_rst    <= 1'b1;
            busy       <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/pgm_rom_loader.md
Name: pgm_rom_loader

Overview:
Sequences the program-ROM write port and CPU reset around an HPS file download.
- Pairs little-endian download bytes into 16-bit words and writes them to the external program ROM.
- Pads unwritten ROM space with an erased-flash pattern.
- Holds the CPU core in reset through the load, then for a fixed settle period afterwards.
- Sits between hps_io's ioctl interface and the ROM write port / atmega32u4 reset input, replacing ad-hoc write logic in the top level.

Parameters:
ADDR_W, 14, ROM word-address width; ROM depth = 2**ADDR_W words
FILL_EN, 1, 1 = pad words above the high-water mark after a load; 0 = skip the pad phase
FILL_WORD, 16'hFFFF, value written during padding
HOLD_CYCLES, 64, cycles cpu_rst stays high after load/pad or after reset; min 1

Ports:
clk  in  1  system clock (ioctl domain)
reset_n  in  1  asynchronous active-low reset
ioctl_download  in  1  download in progress
ioctl_wr  in  1  byte strobe, one cycle per byte
ioctl_addr  in  ADDR_W+1  byte address
ioctl_dout  in  8  byte data
mem_we  out  1  ROM write enable, one-cycle pulse per word
mem_waddr  out  ADDR_W  ROM word address
mem_wdata  out  16  ROM word data {high byte, low byte}
cpu_rst  out  1  active-high reset to the CPU core
busy  out  1  high in every state except RUN
load_words  out  ADDR_W+1  words written from download data (excludes pad) in the last load

Behaviour:
- Reset values (async, on reset_n=0): state HOLD, hold counter = HOLD_CYCLES-1, cpu_rst=1, busy=1, mem_we=0, mem_waddr=0, mem_wdata=0, load_words=0, pend_valid=0, hwm=0.
- All outputs are registered.
- States: IDLE-free FSM: LOAD, FLUSH, PAD, HOLD, RUN.
- Any state, ioctl_download rising (prev 0, now 1):
  - go to LOAD;
  - cpu_rst=1;
  - pend_valid=0, hwm=0, load_words=0.
  - This overrides the current activity, so a download restart mid-PAD or mid-HOLD aborts it.
- LOAD, per ioctl_wr:
  - Even byte address: latch pend_byte and pend_word = addr[ADDR_W:1]; set pend_valid.
  - Odd byte address with pend_valid and matching word: next cycle mem_we=1, mem_waddr=word, mem_wdata={dout, pend_byte}; clear pend_valid; load_words+1; hwm = max(hwm, word+1).
  - Odd byte address with no matching pending byte: the byte is dropped; pend_valid is cleared; nothing is written.
- A second even byte while pend_valid replaces the pending byte; no write occurs.
- Write latency is one cycle after the completing byte strobe.
- ioctl_wr outside LOAD is ignored.
- LOAD, ioctl_download falling:
  - If pend_valid: go to FLUSH.
  - Else, if FILL_EN and hwm < 2**ADDR_W: go to PAD.
  - Else: go to HOLD.
- FLUSH: one cycle; writes {8'hFF, pend_byte} to pend_word; counts it in load_words and hwm; then follows the same PAD/HOLD decision as LOAD.
- PAD:
  - One write per cycle of FILL_WORD to addresses hwm .. 2**ADDR_W-1, ascending.
  - After the write of the last address, go to HOLD.
  - If hwm=0, the whole ROM is padded.
  - The pad counter is ADDR_W+1 bits wide, so no wrap occurs at the final address.
- HOLD:
  - Load the counter with HOLD_CYCLES-1 on entry.
  - Decrement each cycle; at 0 go to RUN.
  - cpu_rst stays high throughout.
- RUN: cpu_rst=0, busy=0, mem_we=0.
- Write ordering: mem_we is never asserted on consecutive cycles with the same address; PAD never overlaps LOAD writes.

Test Plan:
- Reset, then release: cpu_rst=1 for exactly 64 cycles after reset_n rises, busy=1 over the same span; then cpu_rst=0, busy=0; no mem_we pulses.
- Download 4 bytes 0x11,0x22,0x33,0x44 at addr 0..3, FILL_EN=0:
  - Writes word0=0x2211 and word1=0x4433, each one cycle after the odd strobe.
  - load_words=2.
  - cpu_rst falls 64 cycles after download ends.
- Download 3 bytes 0xAA,0xBB,0xCC: writes 0xBBAA at word 0; FLUSH writes 0xFFCC at word 1; load_words=2.
- FILL_EN=1, ADDR_W=4, 2-word download: PAD writes 0xFFFF to words 2..15 on 14 consecutive cycles, then HOLD; no write to word 0 or 1.
- Out-of-order bytes (odd addr 1 first, then addr 0, then addr 3): no write occurs; pending byte from addr 0 is discarded at addr 3; load_words=0.
- ioctl_download re-asserted mid-PAD: pad writes stop the next cycle; state is LOAD, load_words=0, cpu_rst stays 1.
